// File: rtl/bananachine_pkg.sv
// Shared encodings for the bananachine core: opcodes, ext codes, ALU control
// codes, sequencer states, branch conditions and PSR flag positions.
package bananachine_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    localparam logic [3:0] EXT_AND   = 4'b0001;
    localparam logic [3:0] EXT_OR    = 4'b0010;
    localparam logic [3:0] EXT_XOR   = 4'b0011;
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_ADDU  = 4'b0110;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [5:0] ALU_CONT_LUI   = 6'b111111;
    localparam logic [5:0] ALU_CONT_LSH   = 6'b100101;
    localparam logic [5:0] ALU_CONT_BCOND = 6'b111100;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_BCOND, K_JCOND, K_LOAD, K_STOR, K_ILLEGAL
    } kind_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    // R-type ext values the ALU implements; everything else traps to HALT.
    function automatic logic rtype_ext_legal(input logic [3:0] ext);
        case (ext)
            EXT_AND, EXT_OR, EXT_XOR, EXT_ADD,
            EXT_ADDU, EXT_SUB, EXT_CMP, EXT_MOV: rtype_ext_legal = 1'b1;
            default:                             rtype_ext_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator over the latched PSR. Purely combinational
// so the pipelined core can drop it into any stage.
module cond_eval
    import bananachine_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] psr_q,
    output logic             taken
);

    logic c, l, f, z, n;
    logic unused_psr;

    assign c = psr_q[PSR_C];
    assign l = psr_q[PSR_L];
    assign f = psr_q[PSR_F];
    assign z = psr_q[PSR_Z];
    assign n = psr_q[PSR_N];
    assign unused_psr = ^{psr_q[WIDTH-1:8], psr_q[4:3], psr_q[1]};

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_HI: taken = l;
            COND_LS: taken = ~l;
            COND_GT: taken = n;
            COND_LE: taken = ~n;
            COND_FS: taken = f;
            COND_FC: taken = ~f;
            COND_LO: taken = ~l & ~z;
            COND_HS: taken = l | z;
            COND_LT: taken = ~n & ~z;
            COND_GE: taken = n | z;
            COND_UC: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM sequencer for the 16-bit ALU and register
// file: owns PC, IR and latched PSR, and runs the req/ack memory port.
module alu_seq_ctrl
    import bananachine_pkg::*;
#(
    parameter int               WIDTH         = 16,
    parameter int               ALU_CONT_BITS = 6,
    parameter logic [WIDTH-1:0] RESET_PC      = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic                     mem_ack,
    output logic [3:0]               rf_ra,
    output logic [3:0]               rf_rb,
    input  logic [WIDTH-1:0]         rf_rdata_a,
    input  logic [WIDTH-1:0]         rf_rdata_b,
    output logic                     rf_we,
    output logic [3:0]               rf_wa,
    output logic [WIDTH-1:0]         rf_wdata,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [ALU_CONT_BITS-1:0] alu_cont,
    output logic                     alu_reset_n,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic [WIDTH-1:0]         psr_flags,
    output logic [WIDTH-1:0]         pc,
    output logic                     halted
);

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] ir_reg;
    logic [WIDTH-1:0] psr_reg;

    logic [3:0] opcode, rdest, ext, rsrc;
    assign opcode = ir_reg[15:12];
    assign rdest  = ir_reg[11:8];
    assign ext    = ir_reg[7:4];
    assign rsrc   = ir_reg[3:0];

    logic [WIDTH-1:0] imm_sext, imm_zext, pc_inc;
    assign imm_sext = {{(WIDTH-8){ir_reg[7]}}, ir_reg[7:0]};
    assign imm_zext = {{(WIDTH-8){1'b0}}, ir_reg[7:0]};
    assign pc_inc   = pc_reg + WIDTH'(1);

    kind_t            kind;
    logic [5:0]       alu_code;
    logic             use_imm;
    logic [WIDTH-1:0] imm_val;
    logic             writes_rf;
    logic             updates_psr;

    always_comb begin
        kind        = K_ILLEGAL;
        alu_code    = 6'd0;
        use_imm     = 1'b0;
        imm_val     = '0;
        writes_rf   = 1'b0;
        updates_psr = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (rtype_ext_legal(ext)) begin
                    kind        = K_ALU;
                    alu_code    = {2'b00, ext};
                    writes_rf   = (ext != EXT_CMP);
                    updates_psr = (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP);
                end
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                kind      = K_ALU;
                alu_code  = {2'b00, opcode};
                use_imm   = 1'b1;
                imm_val   = imm_zext;
                writes_rf = 1'b1;
            end
            OP_ADDI, OP_ADDUI, OP_SUBI, OP_CMPI, OP_MOVI: begin
                kind        = K_ALU;
                alu_code    = {2'b00, opcode};
                use_imm     = 1'b1;
                imm_val     = imm_sext;
                writes_rf   = (opcode != OP_CMPI);
                updates_psr = (opcode == OP_ADDI) || (opcode == OP_SUBI) || (opcode == OP_CMPI);
            end
            OP_LUI: begin
                // The ALU does the shift; it only needs the raw byte.
                kind      = K_ALU;
                alu_code  = ALU_CONT_LUI;
                use_imm   = 1'b1;
                imm_val   = imm_zext;
                writes_rf = 1'b1;
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH) begin
                    kind      = K_ALU;
                    alu_code  = ALU_CONT_LSH;
                    writes_rf = 1'b1;
                end
            end
            OP_BCOND: begin
                kind     = K_BCOND;
                alu_code = ALU_CONT_BCOND;
            end
            OP_MEM: begin
                case (ext)
                    EXT_LOAD:  kind = K_LOAD;
                    EXT_STOR:  kind = K_STOR;
                    EXT_JCOND: kind = K_JCOND;
                    default:   kind = K_ILLEGAL;
                endcase
            end
            default: kind = K_ILLEGAL;
        endcase
    end

    logic taken;

    cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
        .cond  (rdest),
        .psr_q (psr_reg),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            pc_reg    <= RESET_PC;
            ir_reg    <= '0;
            psr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir_reg    <= mem_rdata;
                        state_reg <= ST_DECODE;
                    end
                end
                ST_DECODE: state_reg <= (kind == K_ILLEGAL) ? ST_HALT : ST_EXEC;
                ST_EXEC: begin
                    if (updates_psr) psr_reg <= psr_flags;
                    case (kind)
                        K_BCOND: pc_reg <= taken ? alu_out : pc_inc;
                        K_JCOND: pc_reg <= taken ? rf_rdata_b : pc_inc;
                        K_LOAD, K_STOR: pc_reg <= pc_reg;
                        default: pc_reg <= pc_inc;
                    endcase
                    state_reg <= (kind == K_LOAD || kind == K_STOR) ? ST_MEM : ST_FETCH;
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        pc_reg    <= pc_inc;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_HALT: state_reg <= ST_HALT;
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

    // Outputs decode from registered state/IR; EXEC and MEM pass the
    // datapath results straight through so the write lands in the same
    // cycle. Everything is forced low while reset is high so an in-flight
    // handshake is dropped immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_ra     = 4'd0;
        rf_rb     = 4'd0;
        rf_we     = 1'b0;
        rf_wa     = 4'd0;
        rf_wdata  = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_cont  = '0;
        if (!reset) begin
            case (state_reg)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_reg;
                end
                ST_DECODE: begin
                    rf_ra = rdest;
                    rf_rb = rsrc;
                end
                ST_EXEC: begin
                    rf_ra    = rdest;
                    rf_rb    = rsrc;
                    alu_cont = ALU_CONT_BITS'(alu_code);
                    if (kind == K_BCOND) begin
                        alu_a = pc_reg;
                        alu_b = imm_zext;
                    end else begin
                        alu_a = rf_rdata_a;
                        alu_b = use_imm ? imm_val : rf_rdata_b;
                    end
                    if (kind == K_ALU && writes_rf) begin
                        rf_we    = 1'b1;
                        rf_wa    = rdest;
                        rf_wdata = alu_out;
                    end
                end
                ST_MEM: begin
                    rf_ra    = rdest;
                    rf_rb    = rsrc;
                    mem_req  = 1'b1;
                    mem_addr = rf_rdata_b;
                    if (kind == K_STOR) begin
                        mem_we    = 1'b1;
                        mem_wdata = rf_rdata_a;
                    end
                    if (kind == K_LOAD && mem_ack) begin
                        rf_we    = 1'b1;
                        rf_wa    = rdest;
                        rf_wdata = mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_reset_n = ~reset;
    assign pc          = reset ? '0 : pc_reg;
    assign halted      = ~reset & (state_reg == ST_HALT);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: the bench stands in for memory, register
// file and ALU, driving hand-computed values cycle by cycle.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  rf_ra, rf_rb, rf_wa;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [15:0] alu_a, alu_b, alu_out, psr_flags, pc;
    logic [5:0]  alu_cont;
    logic        alu_reset_n, halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(16), .ALU_CONT_BITS(6), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont), .alu_reset_n(alu_reset_n),
        .alu_out(alu_out), .psr_flags(psr_flags), .pc(pc), .halted(halted)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // FETCH with zero-wait ack, then DECODE; returns at the start of EXEC.
    task automatic fetch(input logic [15:0] word, input logic [15:0] exp_pc);
        mem_ack   = 1'b1;
        mem_rdata = word;
        settle();
        check("fetch_req", 16'(mem_req), 16'h0001);
        check("fetch_addr", mem_addr, exp_pc);
        check("fetch_rf_we", 16'(rf_we), 16'h0000);
        next();
        mem_ack = 1'b0;
        settle();
        check("decode_req", 16'(mem_req), 16'h0000);
        check("decode_ra", 16'(rf_ra), 16'(word[11:8]));
        check("decode_rb", 16'(rf_rb), 16'(word[3:0]));
        next();
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        rf_rdata_a = '0; rf_rdata_b = '0; alu_out = '0; psr_flags = '0;
        next(); next(); settle();
        check("rst_pc", pc, 16'h0000);
        check("rst_mem_req", 16'(mem_req), 16'h0000);
        check("rst_rf_we", 16'(rf_we), 16'h0000);
        check("rst_halted", 16'(halted), 16'h0000);
        check("rst_alu_reset_n", 16'(alu_reset_n), 16'h0000);
        reset = 1'b0;

        // ADDI R1,#5 at 0: write in cycle 3
        fetch(16'h5105, 16'h0000);
        rf_rdata_a = 16'h0010; alu_out = 16'h0015; settle();
        check("addi_rf_we", 16'(rf_we), 16'h0001);
        check("addi_alu_cont", 16'(alu_cont), 16'h0005);
        check("addi_alu_a", alu_a, 16'h0010);
        check("addi_alu_b", alu_b, 16'h0005);
        check("addi_rf_wa", 16'(rf_wa), 16'h0001);
        check("addi_rf_wdata", rf_wdata, 16'h0015);
        check("alu_reset_n_run", 16'(alu_reset_n), 16'h0001);
        next();

        // ADD R2,R1 at 1: write in cycle 6
        fetch(16'h0251, 16'h0001);
        rf_rdata_a = 16'h0003; rf_rdata_b = 16'h0015; alu_out = 16'h0018; settle();
        check("add_rf_we", 16'(rf_we), 16'h0001);
        check("add_rf_wa", 16'(rf_wa), 16'h0002);
        check("add_alu_b", alu_b, 16'h0015);
        check("add_alu_cont", 16'(alu_cont), 16'h0005);
        check("add_rf_wdata", rf_wdata, 16'h0018);
        next();

        // CMP R1,R2 equal (Z=1) at 2, ANDI at 3, BEQ -2 at 4 -> taken to 2
        fetch(16'h01B2, 16'h0002);
        rf_rdata_a = 16'h0007; rf_rdata_b = 16'h0007; alu_out = 16'h0000;
        psr_flags = 16'h0040; settle();
        check("cmp_rf_we", 16'(rf_we), 16'h0000);
        check("cmp_alu_cont", 16'(alu_cont), 16'h000B);
        next();
        psr_flags = 16'h0000;
        fetch(16'h17FF, 16'h0003);
        rf_rdata_a = 16'h1234; alu_out = 16'h0034; settle();
        check("andi_zext_b", alu_b, 16'h00FF);
        check("andi_rf_we", 16'(rf_we), 16'h0001);
        next();
        fetch(16'hC0FE, 16'h0004);
        alu_out = 16'h0002; settle();
        check("beq_alu_a", alu_a, 16'h0004);
        check("beq_alu_b", alu_b, 16'h00FE);
        check("beq_alu_cont", 16'(alu_cont), 16'h003C);
        check("beq_rf_we", 16'(rf_we), 16'h0000);
        next();

        // Same loop with a!=b (Z=0): BEQ falls through to 5
        fetch(16'h01B2, 16'h0002);
        rf_rdata_a = 16'h0007; rf_rdata_b = 16'h0008; psr_flags = 16'h0004; settle();
        next();
        psr_flags = 16'h0000;
        fetch(16'h17FF, 16'h0003);
        settle();
        next();
        fetch(16'hC0FE, 16'h0004);
        alu_out = 16'h0002; settle();
        next();

        // LOAD R3,(R4) at 5 with ack two cycles late
        fetch(16'h4304, 16'h0005);
        settle();
        check("load_exec_req", 16'(mem_req), 16'h0000);
        check("load_exec_rf_we", 16'(rf_we), 16'h0000);
        next();
        rf_rdata_b = 16'h0100; mem_ack = 1'b0; settle();
        check("load_wait1_req", 16'(mem_req), 16'h0001);
        check("load_wait1_addr", mem_addr, 16'h0100);
        check("load_wait1_we", 16'(mem_we), 16'h0000);
        check("load_wait1_rf_we", 16'(rf_we), 16'h0000);
        next(); settle();
        check("load_wait2_req", 16'(mem_req), 16'h0001);
        check("load_wait2_addr", mem_addr, 16'h0100);
        next();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; settle();
        check("load_rf_we", 16'(rf_we), 16'h0001);
        check("load_rf_wa", 16'(rf_wa), 16'h0003);
        check("load_rf_wdata", rf_wdata, 16'hBEEF);
        next();

        // STOR R5,(R6) at 6
        fetch(16'h4546, 16'h0006);
        settle();
        next();
        rf_rdata_a = 16'h1234; rf_rdata_b = 16'h0200; mem_ack = 1'b1; settle();
        check("stor_we", 16'(mem_we), 16'h0001);
        check("stor_wdata", mem_wdata, 16'h1234);
        check("stor_addr", mem_addr, 16'h0200);
        check("stor_rf_we", 16'(rf_we), 16'h0000);
        next();
        mem_ack = 1'b0;

        // Jcond always (R1 -> 0x0030), then Jcond never falls through to 0x31
        fetch(16'h4EC1, 16'h0007);
        rf_rdata_b = 16'h0030; settle();
        next();
        fetch(16'h4FC1, 16'h0030);
        rf_rdata_b = 16'h0099; settle();
        next();

        // Illegal R-type ext: halt, no further requests, reset recovers
        fetch(16'h0E0F, 16'h0031);
        mem_ack = 1'b1; settle();
        check("halt_flag", 16'(halted), 16'h0001);
        check("halt_req", 16'(mem_req), 16'h0000);
        check("halt_rf_we", 16'(rf_we), 16'h0000);
        next(); settle();
        check("halt_sticky", 16'(halted), 16'h0001);
        check("halt_req2", 16'(mem_req), 16'h0000);
        check("halt_pc", pc, 16'h0031);
        mem_ack = 1'b0;
        reset = 1'b1; settle();
        check("halt_rst_req", 16'(mem_req), 16'h0000);
        next();
        reset = 1'b0; settle();
        check("halt_cleared", 16'(halted), 16'h0000);

        // CMP sets Z, then reset during the STOR MEM wait must clear PSR
        fetch(16'h01B2, 16'h0000);
        rf_rdata_a = 16'h0007; rf_rdata_b = 16'h0007; psr_flags = 16'h0040; settle();
        next();
        psr_flags = 16'h0000;
        fetch(16'h4546, 16'h0001);
        settle();
        next();
        mem_ack = 1'b0; rf_rdata_b = 16'h0200; settle();
        check("stor_wait_req", 16'(mem_req), 16'h0001);
        next();
        reset = 1'b1; settle();
        check("midrst_req", 16'(mem_req), 16'h0000);
        check("midrst_we", 16'(mem_we), 16'h0000);
        check("midrst_addr", mem_addr, 16'h0000);
        next();
        reset = 1'b0;
        fetch(16'hC0FE, 16'h0000);
        alu_out = 16'h0040; settle();
        next();
        mem_ack = 1'b0; settle();
        check("psr_cleared_pc", pc, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
